// File: rtl/seven_seg_pkg.sv
// Shared constants, scan state encoding and the digit-code to segment decode
// for the seven-segment display driver.
package seven_seg_pkg;

    localparam logic [3:0] CODE_MINUS = 4'hA;
    localparam logic [3:0] CODE_BLANK = 4'hF;
    localparam logic [7:0] SEG_BLANK  = 8'hFF;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BLANK = 2'd1,
        ST_SHOW  = 2'd2
    } scan_state_e;

    // Active-low segments {a,b,c,d,e,f,g}; codes B..F render blank.
    function automatic logic [6:0] seg_decode(input logic [3:0] code);
        logic [6:0] s;
        case (code)
            4'h0:       s = 7'b0000001;
            4'h1:       s = 7'b1001111;
            4'h2:       s = 7'b0010010;
            4'h3:       s = 7'b0000110;
            4'h4:       s = 7'b1001100;
            4'h5:       s = 7'b0100100;
            4'h6:       s = 7'b0100000;
            4'h7:       s = 7'b0001111;
            4'h8:       s = 7'b0000000;
            4'h9:       s = 7'b0000100;
            CODE_MINUS: s = 7'b1111110;
            default:    s = 7'b1111111;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/seven_seg_decode.sv
// Combinational single-digit decoder: 4-bit code to active-low segments a..g.
module seven_seg_decode
    import seven_seg_pkg::*;
(
    input  logic [3:0] i_code,
    output logic [6:0] o_seg_c
);

    assign o_seg_c = seg_decode(i_code);

endmodule

// File: rtl/seven_seg_scan.sv
// Time-multiplexed N-digit common-anode seven-segment driver with anti-ghost
// blank gap, per-frame input snapshot and optional leading-zero suppression.
module seven_seg_scan
    import seven_seg_pkg::*;
#(
    parameter int unsigned NUM_DIGITS  = 4,
    parameter int unsigned REFRESH_DIV = 100000,
    parameter int unsigned BLANK_CYC   = 1000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic                    lz_blank,
    input  logic [4*NUM_DIGITS-1:0] digits,
    input  logic [NUM_DIGITS-1:0]   dots,
    output logic [7:0]              seg,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame_tick
);

    localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int unsigned DIV_W = $clog2(REFRESH_DIV);
    localparam int unsigned DIG_W = 4 * NUM_DIGITS;

    localparam logic [IDX_W-1:0]      IDX_LAST   = IDX_W'(NUM_DIGITS - 1);
    localparam logic [DIV_W-1:0]      DIV_LAST   = DIV_W'(REFRESH_DIV - 1);
    localparam logic [DIV_W-1:0]      BLANK_LAST = DIV_W'((BLANK_CYC > 0) ? BLANK_CYC - 1 : 0);
    localparam logic [NUM_DIGITS-1:0] AN_ONE     = NUM_DIGITS'(1);
    localparam scan_state_e           SLOT_FIRST = (BLANK_CYC > 0) ? ST_BLANK : ST_SHOW;

    scan_state_e           r_state;
    logic [IDX_W-1:0]      r_idx;
    logic [DIV_W-1:0]      r_div;
    logic [DIG_W-1:0]      r_digits_snap;
    logic [NUM_DIGITS-1:0] r_dots_snap;
    logic [7:0]            r_seg;
    logic [NUM_DIGITS-1:0] r_an;
    logic                  r_tick;

    scan_state_e           w_state_nxt;
    logic [IDX_W-1:0]      w_idx_nxt;
    logic [DIV_W-1:0]      w_div_nxt;
    logic                  w_take;
    logic [DIG_W-1:0]      w_digits_nxt;
    logic [NUM_DIGITS-1:0] w_dots_nxt;
    logic [NUM_DIGITS-1:0] w_supp;
    logic                  w_lead;
    logic [3:0]            w_code;
    logic                  w_dp;
    logic [6:0]            w_seg7;
    logic [7:0]            w_seg_nxt;
    logic [NUM_DIGITS-1:0] w_an_nxt;

    // Slot sequencing: divider runs across the whole slot, blank gap first.
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_div_nxt   = r_div;
        w_take      = 1'b0;
        if (!en) begin
            w_state_nxt = ST_IDLE;
            w_idx_nxt   = '0;
            w_div_nxt   = '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_state_nxt = SLOT_FIRST;
                    w_idx_nxt   = '0;
                    w_div_nxt   = '0;
                    w_take      = 1'b1;
                end
                ST_BLANK: begin
                    w_div_nxt = r_div + DIV_W'(1);
                    if (r_div == BLANK_LAST) begin
                        w_state_nxt = ST_SHOW;
                    end
                end
                ST_SHOW: begin
                    if (r_div == DIV_LAST) begin
                        w_div_nxt   = '0;
                        w_state_nxt = SLOT_FIRST;
                        if (r_idx == IDX_LAST) begin
                            w_idx_nxt = '0;
                            w_take    = 1'b1;
                        end else begin
                            w_idx_nxt = r_idx + IDX_W'(1);
                        end
                    end else begin
                        w_div_nxt = r_div + DIV_W'(1);
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                    w_idx_nxt   = '0;
                    w_div_nxt   = '0;
                end
            endcase
        end
    end

    // Digit selection from the next-cycle snapshot so outputs switch on the slot edge.
    always_comb begin
        w_digits_nxt = w_take ? digits : r_digits_snap;
        w_dots_nxt   = w_take ? dots   : r_dots_snap;
        w_supp       = '0;
        w_lead       = lz_blank;
        // Zeros above the first visible code (1..9, minus) are blanked; codes B..F keep scanning.
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            if (w_digits_nxt[4*i +: 4] == 4'h0) begin
                w_supp[i] = w_lead;
            end else if (w_digits_nxt[4*i +: 4] <= CODE_MINUS) begin
                w_lead = 1'b0;
            end
        end
        w_code = CODE_BLANK;
        w_dp   = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (w_idx_nxt == IDX_W'(i)) begin
                w_code = w_supp[i] ? CODE_BLANK : w_digits_nxt[4*i +: 4];
                w_dp   = w_dots_nxt[i];
            end
        end
    end

    seven_seg_decode u_decode (
        .i_code  (w_code),
        .o_seg_c (w_seg7)
    );

    always_comb begin
        w_an_nxt  = '1;
        w_seg_nxt = SEG_BLANK;
        if (w_state_nxt == ST_SHOW) begin
            w_an_nxt  = ~(AN_ONE << w_idx_nxt);
            w_seg_nxt = {~w_dp, w_seg7};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= ST_IDLE;
            r_idx         <= '0;
            r_div         <= '0;
            r_digits_snap <= '0;
            r_dots_snap   <= '0;
            r_seg         <= SEG_BLANK;
            r_an          <= '1;
            r_tick        <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_div   <= w_div_nxt;
            if (w_take) begin
                r_digits_snap <= digits;
                r_dots_snap   <= dots;
            end
            r_seg  <= w_seg_nxt;
            r_an   <= w_an_nxt;
            r_tick <= w_take;
        end
    end

    assign seg        = r_seg;
    assign an         = r_an;
    assign frame_tick = r_tick;

endmodule

// File: tb/tb_seven_seg_scan.sv
// Self-checking bench for seven_seg_scan (4 digits, 8-cycle slots, 2-cycle blank gap).
module tb_seven_seg_scan;

    localparam int unsigned ND = 4;
    localparam int unsigned RD = 8;
    localparam int unsigned BC = 2;
    localparam int NV = 10;

    typedef struct {
        logic [3:0] an;
        logic [7:0] seg;
    } exp_t;

    typedef struct {
        logic [15:0]     digits;
        logic [3:0]      dots;
        logic            lz;
        logic [3:0][7:0] segs;
    } vec_t;

    logic        clk;
    logic        rst;
    logic        en;
    logic        lz_blank;
    logic [15:0] digits;
    logic [3:0]  dots;
    logic [7:0]  seg;
    logic [3:0]  an;
    logic        frame_tick;

    exp_t            q[$];
    vec_t            vecs[NV];
    logic [3:0][7:0] s1234;
    logic [3:0][7:0] s5678;
    int              n_tests;
    int              n_fail;
    int              bad;
    logic [3:0]      prev_an;

    seven_seg_scan #(
        .NUM_DIGITS  (ND),
        .REFRESH_DIV (RD),
        .BLANK_CYC   (BC)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .lz_blank   (lz_blank),
        .digits     (digits),
        .dots       (dots),
        .seg        (seg),
        .an         (an),
        .frame_tick (frame_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic push_frame(input logic [3:0][7:0] s);
        for (int i = 0; i < 4; i++) begin
            exp_t       e;
            logic [3:0] a;
            a     = 4'b0001 << i;
            e.an  = ~a;
            e.seg = s[i];
            q.push_back(e);
        end
    endtask

    task automatic wait_tick(input string name);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (frame_tick !== 1'b1 && n < 100);
        check({name, "_tick"}, 32'(frame_tick), 32'd1);
    endtask

    task automatic wait_empty(input string name);
        int n;
        n = 0;
        while (q.size() != 0 && n < 80) begin
            @(negedge clk);
            n++;
        end
        check({name, "_drain"}, 32'(q.size()), 32'd0);
        q.delete();
    endtask

    task automatic wait_an(input logic [3:0] target, input string name);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (an !== target && n < 100);
        check({name, "_reach"}, 32'(an), 32'(target));
    endtask

    // Scoreboard consumer: one expected entry per slot start (blank -> lit anode).
    initial begin
        prev_an = 4'hF;
        forever begin
            @(negedge clk);
            if (rst === 1'b1 && prev_an == 4'hF && an != 4'hF && q.size() > 0) begin
                exp_t e;
                e = q.pop_front();
                check("slot_an", 32'(an), 32'(e.an));
                check("slot_seg", 32'(seg), 32'(e.seg));
                check("slot_onehot", 32'($countones(~an)), 32'd1);
            end
            prev_an = an;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, tests %0d", n_tests);
        $fatal(1, "watchdog");
    end

    initial begin
        n_tests  = 0;
        n_fail   = 0;
        s1234    = {8'hCF, 8'h92, 8'h86, 8'hCC};
        s5678    = {8'hA4, 8'hA0, 8'h8F, 8'h80};
        vecs[0] = '{16'h1234, 4'h0, 1'b0, {8'hCF, 8'h92, 8'h86, 8'hCC}};
        vecs[1] = '{16'h5678, 4'h0, 1'b0, {8'hA4, 8'hA0, 8'h8F, 8'h80}};
        vecs[2] = '{16'h0A05, 4'h0, 1'b1, {8'hFF, 8'hFE, 8'h81, 8'hA4}};
        vecs[3] = '{16'h0000, 4'h0, 1'b1, {8'hFF, 8'hFF, 8'hFF, 8'h81}};
        vecs[4] = '{16'hF321, 4'h4, 1'b0, {8'hFF, 8'h06, 8'h92, 8'hCF}};
        vecs[5] = '{16'h0000, 4'hF, 1'b0, {8'h01, 8'h01, 8'h01, 8'h01}};
        vecs[6] = '{16'h0A05, 4'h0, 1'b0, {8'h81, 8'hFE, 8'h81, 8'hA4}};
        vecs[7] = '{16'h0090, 4'h8, 1'b1, {8'h7F, 8'hFF, 8'h84, 8'h81}};
        vecs[8] = '{16'h8888, 4'hF, 1'b1, {8'h00, 8'h00, 8'h00, 8'h00}};
        vecs[9] = '{16'h0007, 4'h1, 1'b1, {8'hFF, 8'hFF, 8'hFF, 8'h0F}};

        rst = 1'b1; en = 1'b0; lz_blank = 1'b0; digits = '0; dots = '0;
        #1 rst = 1'b0;
        #2;
        check("reset_seg", 32'(seg), 32'hFF);
        check("reset_an", 32'(an), 32'hF);
        check("reset_tick", 32'(frame_tick), 32'd0);

        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        bad = 0;
        repeat (1000) begin
            @(negedge clk);
            if (seg !== 8'hFF || an !== 4'hF || frame_tick !== 1'b0) bad++;
        end
        check("idle_blank_cycles", 32'(bad), 32'd0);

        // Basic scan: full frame cycle by cycle starting at the tick cycle.
        digits = 16'h1234; en = 1'b1;
        wait_tick("scan_start");
        for (int c = 0; c < 32; c++) begin
            logic [3:0] ea;
            logic [7:0] es;
            int         sl;
            sl = c / 8;
            if (c % 8 < 2) begin
                ea = 4'hF;
                es = 8'hFF;
            end else begin
                ea = 4'b0001 << sl;
                ea = ~ea;
                es = s1234[sl];
            end
            check($sformatf("scan_an_c%0d", c), 32'(an), 32'(ea));
            check($sformatf("scan_seg_c%0d", c), 32'(seg), 32'(es));
            check($sformatf("scan_tick_c%0d", c), 32'(frame_tick), 32'(c == 0));
            @(negedge clk);
        end
        check("tick_period_32", 32'(frame_tick), 32'd1);

        for (int v = 0; v < NV; v++) begin
            digits   = vecs[v].digits;
            dots     = vecs[v].dots;
            lz_blank = vecs[v].lz;
            wait_tick($sformatf("vec%0d", v));
            push_frame(vecs[v].segs);
            wait_empty($sformatf("vec%0d", v));
        end

        // Mid-frame input change stays hidden until the next snapshot.
        digits = 16'h1234; dots = 4'h0; lz_blank = 1'b0;
        wait_tick("snap_a");
        push_frame(s1234);
        wait_an(4'b1101, "snap_slot1");
        digits = 16'h5678;
        wait_empty("snap_a");
        wait_tick("snap_b");
        push_frame(s5678);
        wait_empty("snap_b");

        // en falls during SHOW of idx 2.
        wait_an(4'b1011, "enfall_slot2");
        en = 1'b0;
        @(negedge clk);
        check("enfall_an", 32'(an), 32'hF);
        check("enfall_seg", 32'(seg), 32'hFF);
        bad = 0;
        repeat (5) begin
            @(negedge clk);
            if (seg !== 8'hFF || an !== 4'hF || frame_tick !== 1'b0) bad++;
        end
        check("enfall_hold", 32'(bad), 32'd0);

        // en rises just after an edge: blank gap, then idx 0.
        @(posedge clk);
        #1 en = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check($sformatf("enrise_an_k%0d", k), 32'(an), (k == 3) ? 32'hE : 32'hF);
            check($sformatf("enrise_seg_k%0d", k), 32'(seg), (k == 3) ? 32'h80 : 32'hFF);
            check($sformatf("enrise_tick_k%0d", k), 32'(frame_tick), 32'(k == 1));
        end

        // Asynchronous reset mid-slot blanks before any clock edge.
        wait_an(4'b1101, "rst_slot1");
        #2 rst = 1'b0;
        #1;
        check("async_rst_an", 32'(an), 32'hF);
        check("async_rst_seg", 32'(seg), 32'hFF);
        check("async_rst_tick", 32'(frame_tick), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        wait_tick("post_rst");
        push_frame(s5678);
        wait_empty("post_rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
